// File: rtl/nes_clk_pkg.sv
// Shared constants for the NES clock-enable generator: default accumulator width,
// channel indices, NTSC increments and the config-path state encoding.
package nes_clk_pkg;

  localparam int ACC_W_DEF = 24;

  localparam int CH_CPU      = 0;
  localparam int CH_PPU      = 1;
  localparam int CH_PPU_SLOW = 2;
  localparam int CH_SHIFT    = 3;
  localparam int CH_VGA      = 4;

  // Increments for a 50 MHz base and a 24-bit accumulator.
  localparam logic [ACC_W_DEF-1:0] INC_CPU = 24'd600548;   // 1.789773 MHz
  localparam logic [ACC_W_DEF-1:0] INC_PPU = 24'd1801644;  // 5.369318 MHz
  localparam logic [ACC_W_DEF-1:0] INC_VGA = 24'd8388608;  // 25 MHz

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/nes_nco_ch.sv
// One fractional NCO channel: phase accumulator, reloadable increment,
// registered carry strobe and a divide-by-two toggle.
module nes_nco_ch
  import nes_clk_pkg::*;
#(
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RST = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [ACC_W-1:0] ld_inc,
  output logic             ce,
  output logic             clk_div,
  output logic             carry,
  output logic             inc_zero
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum      = {1'b0, acc} + {1'b0, inc};
  assign carry    = sum[ACC_W];
  assign inc_zero = (inc == '0);

  // The increment reload is independent of sync/en so a pending value
  // always lands on the edge the top level picks.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc <= INC_RST;
    end else if (ld) begin
      inc <= ld_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ce      <= 1'b0;
      clk_div <= 1'b0;
    end else if (sync) begin
      acc     <= '0;
      ce      <= 1'b0;
      clk_div <= 1'b0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
      ce  <= carry;
      if (carry) clk_div <= ~clk_div;
    end else begin
      ce <= 1'b0;
    end
  end

endmodule

// File: rtl/nes_ce_gen.sv
// Multi-channel clock-enable generator with a single-entry config shadow that
// retunes a channel only on its own strobe boundary.
module nes_ce_gen
  import nes_clk_pkg::*;
#(
  parameter int                      N_CH     = 5,
  parameter int                      ACC_W    = ACC_W_DEF,
  parameter logic [N_CH*ACC_W-1:0]   INC_INIT = {N_CH{1'b1, {(ACC_W-1){1'b0}}}}
) (
  input  logic                    clk_50_clk,
  input  logic                    reset_reset,
  input  logic [N_CH-1:0]         en,
  input  logic                    sync,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]        cfg_inc,
  output logic                    cfg_err,
  output logic [N_CH-1:0]         ce,
  output logic [N_CH-1:0]         clk_div
);

  localparam int CH_W = $clog2(N_CH);

  cfg_state_t       state, state_nxt;
  logic [CH_W-1:0]  sh_ch;
  logic [ACC_W-1:0] sh_inc;
  logic [N_CH-1:0]  carry, inc_zero, ld;
  logic             accept, ch_ok, apply;

  assign accept = cfg_valid && cfg_ready;
  assign ch_ok  = (int'(cfg_ch) < N_CH);

  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) state <= CFG_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CFG_IDLE: if (accept && ch_ok) state_nxt = CFG_PEND;
      CFG_PEND: if (apply)           state_nxt = CFG_IDLE;
      default:                       state_nxt = CFG_IDLE;
    endcase
  end

  // A stopped target (disabled or zero increment) never strobes, so it takes
  // the update immediately instead of waiting forever.
  always_comb begin
    cfg_ready = (state == CFG_IDLE);
    apply     = (state == CFG_PEND) &&
                (sync || !en[sh_ch] || inc_zero[sh_ch] || carry[sh_ch]);
    ld        = '0;
    if (apply) ld[sh_ch] = 1'b1;
  end

  // Out-of-range requests are swallowed: flagged, never stored.
  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) begin
      sh_ch   <= '0;
      sh_inc  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && !ch_ok;
      if (accept && ch_ok) begin
        sh_ch  <= cfg_ch;
        sh_inc <= cfg_inc;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nes_nco_ch #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk      (clk_50_clk),
      .rst      (reset_reset),
      .en       (en[i]),
      .sync     (sync),
      .ld       (ld[i]),
      .ld_inc   (sh_inc),
      .ce       (ce[i]),
      .clk_div  (clk_div[i]),
      .carry    (carry[i]),
      .inc_zero (inc_zero[i])
    );
  end

endmodule

// File: doc/nes_ce_gen.md
# nes_ce_gen

Parametrised clock-enable generator for the NES core. It replaces the fixed PLL-derived CPU, PPU, PPU-slow, shift and VGA clocks with N_CH fractional NCO channels, all running in the single 50 MHz domain. Each channel emits a one-cycle enable strobe and a 50%-duty divided toggle. Per-channel rates are reprogrammable at run time through a valid/ready port, and every update takes effect glitch-free on that channel's own strobe boundary.

## Interface
- N_CH, 5: number of channels (0 cpu, 1 ppu, 2 ppu_slow, 3 shift, 4 vga by convention).
- ACC_W, 24: accumulator/increment width; strobe rate = f_clk·inc/2^ACC_W.
- INC_INIT, {N_CH{2^(ACC_W-1)}}: packed N_CH×ACC_W reset increments; channel 0 in the LSBs.
- clk_50_clk  in  1  sole clock, 50 MHz.
- reset_reset  in  1  synchronous, active-high reset.
- en  in  N_CH  per-channel run enable.
- sync  in  1  one-cycle pulse; phase-aligns all channels.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid && cfg_ready.
- cfg_ch  in  $clog2(N_CH)  target channel.
- cfg_inc  in  ACC_W  new increment.
- cfg_err  out  1  one-cycle pulse when an out-of-range cfg_ch is accepted.
- ce  out  N_CH  one-cycle enable strobes.
- clk_div  out  N_CH  toggles on each strobe (f = f_ce/2).

## Operation
- Reset values: acc = 0, inc = INC_INIT, ce = 0, clk_div = 0, cfg_ready = 1, cfg_err = 0, pending = none.
- Per channel with en[i] = 1: {carry, acc_next} = acc + inc (ACC_W+1 bits). acc <= acc_next. ce[i] <= carry. clk_div[i] toggles when carry = 1.
- en[i] = 0: acc, inc and clk_div hold. ce[i] = 0 on the next edge.
- inc = 0: the channel is stopped and emits no strobes.
- Config path:
  - A single shadow register holds {ch, inc} plus a pending flag.
  - Accepting a request sets pending and drives cfg_ready = 0 until the update is applied.
  - The pending value is applied on the edge where the target channel's carry = 1, so the new inc is used from the following add.
  - If the target's current inc = 0 or en = 0, the value is applied on the next edge.
  - cfg_ch ≥ N_CH: the request is accepted but not stored. cfg_err pulses, and cfg_ready stays 1.
- sync:
  - On the edge it is sampled high, all acc <= 0, all ce <= 0, all clk_div <= 0, and any pending value is applied immediately.
  - sync overrides en and carry.
- sync and a new accept in the same cycle: sync acts first. The new request enters the shadow register and follows the normal strobe-boundary rule.
- Reset mid-update: the pending update is discarded and inc returns to INC_INIT.

## Timing
- Strobe latency: ce is registered. With inc = 2^(ACC_W-1) after reset release, edge 1 gives acc = 2^(ACC_W-1) and ce = 0; edge 2 gives acc = 0 and ce = 1. The strobe then repeats every 2 cycles.
- clk_div changes on the same edge that ce is asserted.
- cfg_ready falls on the edge after the accept. It rises on the edge after the update is applied. Throughput is at most one update per application.
- Jitter: strobe spacing is floor or ceil of 2^ACC_W/inc cycles. The long-run rate is exact to 1 LSB of inc.
- No combinational path from any input to any output.

## Structure
- Package nes_clk_pkg holds:
  - ACC_W default;
  - channel index localparams CH_CPU = 0, CH_PPU = 1, CH_PPU_SLOW = 2, CH_SHIFT = 3, CH_VGA = 4;
  - NTSC increment constants: CPU 600548 (1.789773 MHz), PPU 1801644 (5.369318 MHz), VGA 8388608 (25 MHz).
- One sub-module, nes_nco_ch, generated N_CH times: accumulator, inc register, load strobe, ce and clk_div.
- The top level owns the shadow register, the handshake and sync fan-out.

## Test plan
- Reset release, default INC_INIT → every ce toggles high every 2nd cycle, first at edge 2; clk_div period 4 cycles.
- cfg ch 4, inc 8388608 → ch4 update waits for its next strobe; afterwards ch4 strobes every 2 cycles with no shortened gap. cfg_ready is low for exactly the wait plus 1 cycle.
- ch0 inc 600548, run 2^24 cycles → exactly 600548 ce pulses; every gap is 27 or 28 cycles.
- en[1] dropped for 10 cycles mid-period → no ch1 strobes during the drop; phase resumes from the held acc with no extra strobe.
- sync during a pending update on a stopped channel, in the same cycle as a new cfg_valid → all acc, ce and clk_div are 0 next cycle. The old pending value is applied. The new request is held and cfg_ready = 0.
- cfg_ch = 7 with N_CH = 5 → cfg_err pulses once, cfg_ready stays 1, and no channel's inc changes.
